alu_multicycle: RTL and testbench

//   Parametrised multi-cycle ALU; successor to the single-cycle datapath ALU. Executes

---
 rtl/alu_multicycle_if.sv | 31 +++
 rtl/alu_multicycle.sv | 167 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle: valid/ready in, valid/ready out,
// plus the architectural HI/LO and status flags.
interface alu_multicycle_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, op, in1, in2, shamt, out_ready,
        input  in_ready, out_valid, result, zero, div_zero, hi, lo
    );

    modport slave (
        input  in_valid, op, in1, in2, shamt, out_ready,
        output in_ready, out_valid, result, zero, div_zero, hi, lo
    );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle EX-stage ALU: single-cycle ops plus iterative MULTU (shift-add)
// and DIVU (restoring) into HI/LO, behind a valid/ready handshake.
module alu_multicycle #(
    parameter int unsigned WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_multicycle_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_SLT   = 4'd4;
    localparam logic [3:0] OP_SLTU  = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_NEQ   = 4'd9;
    localparam logic [3:0] OP_MULTU = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;
    localparam logic [3:0] OP_MFHI  = 4'd12;
    localparam logic [3:0] OP_MFLO  = 4'd13;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DIV, S_DONE} state_e;

    state_e           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] opa_q, opb_q, acc_q, qd_q;
    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic [SHW-1:0]   sh_q;
    logic [CW-1:0]    cnt_q;
    logic             in_ready_q, out_valid_q, div_zero_q;

    logic [WIDTH-1:0] simple_c;
    logic [WIDTH:0]   mul_sum_c, div_sh_c, div_diff_c;
    logic             div_ok_c;

    // Single-cycle ops evaluated from the operands captured at acceptance
    always_comb begin
        simple_c = '0;
        case (op_q)
            OP_ADD:  simple_c = opa_q + opb_q;
            OP_SUB:  simple_c = opa_q - opb_q;
            OP_AND:  simple_c = opa_q & opb_q;
            OP_OR:   simple_c = opa_q | opb_q;
            OP_SLT:  simple_c = WIDTH'($signed(opa_q) < $signed(opb_q));
            OP_SLTU: simple_c = WIDTH'(opa_q < opb_q);
            OP_SLL:  simple_c = opb_q << sh_q;
            OP_SRL:  simple_c = opb_q >> sh_q;
            OP_SRA:  simple_c = $unsigned($signed(opb_q) >>> sh_q);
            OP_NEQ:  simple_c = WIDTH'(opa_q != opb_q);
            OP_MFHI: simple_c = hi_q;
            OP_MFLO: simple_c = lo_q;
            default: simple_c = '0;
        endcase
    end

    // One iteration step: {acc,qd} is the shared HI/LO working pair
    always_comb begin
        mul_sum_c  = {1'b0, acc_q} + (qd_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
        div_sh_c   = {acc_q, qd_q[WIDTH-1]};
        div_ok_c   = (div_sh_c >= {1'b0, opb_q});
        div_diff_c = div_sh_c - {1'b0, opb_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            sh_q        <= '0;
            acc_q       <= '0;
            qd_q        <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q       <= bus.op;
                        opa_q      <= bus.in1;
                        opb_q      <= bus.in2;
                        sh_q       <= bus.shamt;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        case (bus.op)
                            OP_MULTU: begin
                                qd_q    <= bus.in2;
                                state_q <= S_MUL;
                            end
                            OP_DIVU: begin
                                qd_q    <= bus.in1;
                                state_q <= S_DIV;
                            end
                            default: state_q <= S_EXEC;
                        endcase
                    end
                end
                S_EXEC: begin
                    result_q    <= simple_c;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_MUL: begin
                    if (cnt_q == CW'(WIDTH)) begin
                        hi_q        <= acc_q;
                        lo_q        <= qd_q;
                        result_q    <= qd_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        acc_q <= mul_sum_c[WIDTH:1];
                        qd_q  <= {mul_sum_c[0], qd_q[WIDTH-1:1]};
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DIV: begin
                    if (cnt_q == CW'(WIDTH)) begin
                        hi_q        <= acc_q;
                        lo_q        <= qd_q;
                        result_q    <= qd_q;
                        div_zero_q  <= (opb_q == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        // divisor 0 always "fits": quotient all ones, remainder = dividend
                        acc_q <= div_ok_c ? div_diff_c[WIDTH-1:0] : div_sh_c[WIDTH-1:0];
                        qd_q  <= {qd_q[WIDTH-2:0], div_ok_c};
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = (result_q == '0);
    assign bus.div_zero  = div_zero_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH=32): vector table for single-cycle
// ops, hand-written sequences for MULTU/DIVU, backpressure and mid-op reset.
module tb_alu_multicycle;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    alu_multicycle_if #(.WIDTH(32)) bus ();

    alu_multicycle #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op at posedge+1, then count edges until out_valid.
    // bad flags in_ready high or HI/LO moving before the result appears.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, output int lat, output logic bad);
        logic [31:0] hi0, lo0;
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        hi0 = bus.hi;
        lo0 = bus.lo;
        bus.op = op; bus.in1 = a; bus.in2 = b; bus.shamt = sh; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in1 = ~a; bus.in2 = ~b; bus.shamt = ~sh; bus.op = 4'd14;
        lat = 0;
        bad = 1'b0;
        while (lat < 200) begin
            if (bus.out_valid) break;
            if (bus.in_ready || bus.hi !== hi0 || bus.lo !== lo0) bad = 1'b1;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic take(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk(name, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic bad;
        errors = 0;
        checks = 0;

        vecs[0]  = '{"add_wrap", 4'd0,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1};
        vecs[1]  = '{"sub_neg",  4'd1,  32'd5,        32'd7,        5'd0,  32'hFFFFFFFE, 1'b0};
        vecs[2]  = '{"and",      4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0, 1'b0};
        vecs[3]  = '{"or",       4'd3,  32'h12340000, 32'h00005678, 5'd0,  32'h12345678, 1'b0};
        vecs[4]  = '{"slt",      4'd4,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0};
        vecs[5]  = '{"sltu",     4'd5,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1};
        vecs[6]  = '{"sll31",    4'd6,  32'hDEADBEEF, 32'h00000001, 5'd31, 32'h80000000, 1'b0};
        vecs[7]  = '{"srl4",     4'd7,  32'h00000000, 32'h80000000, 5'd4,  32'h08000000, 1'b0};
        vecs[8]  = '{"sra4",     4'd8,  32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0};
        vecs[9]  = '{"neq_eq",   4'd9,  32'd5,        32'd5,        5'd0,  32'h00000000, 1'b1};
        vecs[10] = '{"neq_ne",   4'd9,  32'd5,        32'd6,        5'd0,  32'h00000001, 1'b0};
        vecs[11] = '{"op14",     4'd14, 32'h12345678, 32'h9ABCDEF0, 5'd3,  32'h00000000, 1'b1};
        vecs[12] = '{"op15",     4'd15, 32'h12345678, 32'h9ABCDEF0, 5'd3,  32'h00000000, 1'b1};
        vecs[13] = '{"add_ovf",  4'd0,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0};

        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 4'd0;
        bus.in1 = '0; bus.in2 = '0; bus.shamt = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result",    bus.result,         32'd0);
        chk("rst_zero",      32'(bus.zero),      32'd1);
        chk("rst_hi",        bus.hi,             32'd0);
        chk("rst_lo",        bus.lo,             32'd0);
        chk("rst_div_zero",  32'(bus.div_zero),  32'd0);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, lat, bad);
            chk({vecs[i].name, "_lat"},  32'(lat),        32'd1);
            chk({vecs[i].name, "_res"},  bus.result,      vecs[i].res);
            chk({vecs[i].name, "_zero"}, 32'(bus.zero),   32'(vecs[i].zero));
            take({vecs[i].name, "_idle"});
        end

        // MULTU max*max
        run_op(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, lat, bad);
        chk("mul_lat",  32'(lat),   32'd33);
        chk("mul_hold", 32'(bad),   32'd0);
        chk("mul_res",  bus.result, 32'h00000001);
        chk("mul_hi",   bus.hi,     32'hFFFFFFFE);
        chk("mul_lo",   bus.lo,     32'h00000001);
        take("mul_idle");
        run_op(4'd12, 32'd0, 32'd0, 5'd0, lat, bad);
        chk("mfhi_res", bus.result, 32'hFFFFFFFE);
        take("mfhi_idle");
        run_op(4'd13, 32'd0, 32'd0, 5'd0, lat, bad);
        chk("mflo_res", bus.result, 32'h00000001);
        take("mflo_idle");

        // MULTU carrying entirely into HI
        run_op(4'd10, 32'h00010000, 32'h00010000, 5'd0, lat, bad);
        chk("mul2_hi",   bus.hi,            32'h00000001);
        chk("mul2_lo",   bus.lo,            32'h00000000);
        chk("mul2_zero", 32'(bus.zero),     32'd1);
        chk("mul2_hold", 32'(bad),          32'd0);
        take("mul2_idle");

        // DIVU normal, by zero, then clear
        run_op(4'd11, 32'd100, 32'd7, 5'd0, lat, bad);
        chk("div_lat",  32'(lat),          32'd33);
        chk("div_hold", 32'(bad),          32'd0);
        chk("div_lo",   bus.lo,            32'd14);
        chk("div_hi",   bus.hi,            32'd2);
        chk("div_res",  bus.result,        32'd14);
        chk("div_dz",   32'(bus.div_zero), 32'd0);
        take("div_idle");
        run_op(4'd11, 32'd5, 32'd0, 5'd0, lat, bad);
        chk("div0_lat", 32'(lat),          32'd33);
        chk("div0_lo",  bus.lo,            32'hFFFFFFFF);
        chk("div0_hi",  bus.hi,            32'd5);
        chk("div0_dz",  32'(bus.div_zero), 32'd1);
        take("div0_idle");
        run_op(4'd0, 32'd1, 32'd1, 5'd0, lat, bad);
        chk("dz_sticky", 32'(bus.div_zero), 32'd1);
        take("dz_sticky_idle");
        run_op(4'd11, 32'd8, 32'd2, 5'd0, lat, bad);
        chk("div3_lo", bus.lo,            32'd4);
        chk("div3_hi", bus.hi,            32'd0);
        chk("div3_dz", 32'(bus.div_zero), 32'd0);
        take("div3_idle");

        // Backpressure: result held, new request ignored
        run_op(4'd0, 32'd3, 32'd4, 5'd0, lat, bad);
        bus.op = 4'd1; bus.in1 = 32'd1; bus.in2 = 32'd1; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_result",    bus.result,          32'd7);
            chk("bp_out_valid", 32'(bus.out_valid),  32'd1);
            chk("bp_in_ready",  32'(bus.in_ready),   32'd0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_rel_in_ready",  32'(bus.in_ready),  32'd1);
        chk("bp_rel_out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_rel_result",    bus.result,         32'd7);
        @(posedge clk); #1;
        chk("bp_not_queued", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of MULTU with non-zero HI/LO/div_zero beforehand
        run_op(4'd11, 32'd9, 32'd0, 5'd0, lat, bad);
        chk("pre_rst_dz", 32'(bus.div_zero), 32'd1);
        take("pre_rst_idle");
        bus.op = 4'd10; bus.in1 = 32'd3; bus.in2 = 32'd5; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_result",    bus.result,         32'd0);
        chk("mrst_zero",      32'(bus.zero),      32'd1);
        chk("mrst_hi",        bus.hi,             32'd0);
        chk("mrst_lo",        bus.lo,             32'd0);
        chk("mrst_div_zero",  32'(bus.div_zero),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(4'd0, 32'd2, 32'd3, 5'd0, lat, bad);
        chk("post_rst_lat", 32'(lat),   32'd1);
        chk("post_rst_res", bus.result, 32'd5);
        chk("post_rst_hi",  bus.hi,     32'd0);
        take("post_rst_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
